// File: rtl/issue_queue_pkg.sv
// Shared pipeline types for the decode -> issue -> execute path.
// Used by issue_queue, its pairing checker and the bypass network.
package issue_queue_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  rdst;
    logic        regwrite;
    logic        memtoreg;
    logic        is_mem;
    logic        is_branch;
  } issue_entry_t;

  typedef struct packed {
    logic [4:0] ra1;
    logic [4:0] ra2;
  } bypass_issue_t;

  typedef struct packed {
    logic        valid;
    logic        bypass;
    logic [31:0] data;
  } bypass_output_t;

  typedef struct packed {
    issue_entry_t entry;
    logic [31:0]  op1;
    logic [31:0]  op2;
    logic         byp1;
    logic         byp2;
  } issued_t;

endpackage

// File: rtl/issue_queue_if.sv
// Bundle of decode-side, bypass-side and execute-side signals around the issue queue.
interface issue_queue_if
  import issue_queue_pkg::*;
#(
  parameter int QDEPTH = 8
);
  localparam int CW = $clog2(QDEPTH) + 1;

  // enq_valid/enq_ready: a slot transfers on a cycle where both are high; enq_ready
  // does not depend on enq_valid. ex_ready high loads the issue register that cycle.
  logic                 flush;
  logic [1:0]           enq_valid;
  issue_entry_t [1:0]   enq_data;
  logic                 enq_ready;
  bypass_issue_t [1:0]  byp_query;
  bypass_output_t [1:0] byp_ra1;
  bypass_output_t [1:0] byp_ra2;
  logic                 ex_ready;
  logic [1:0]           iss_valid;
  issued_t [1:0]        iss_data;
  logic [CW-1:0]        count;

  modport master (
    output flush, enq_valid, enq_data, byp_ra1, byp_ra2, ex_ready,
    input  enq_ready, byp_query, iss_valid, iss_data, count
  );

  modport slave (
    input  flush, enq_valid, enq_data, byp_ra1, byp_ra2, ex_ready,
    output enq_ready, byp_query, iss_valid, iss_data, count
  );

endinterface

// File: rtl/issue_pair_check.sv
// Decides whether head1 may issue alongside head0: no RAW on head0's
// destination, not two memory ops, and head0 is not a branch.
module issue_pair_check (
  input  logic       h0_regwrite_i,
  input  logic [4:0] h0_rdst_i,
  input  logic       h0_is_mem_i,
  input  logic       h0_is_branch_i,
  input  logic [4:0] h1_ra1_i,
  input  logic [4:0] h1_ra2_i,
  input  logic       h1_is_mem_i,
  output logic       pair_ok_o
);
  logic raw;

  // r0 is hardwired zero, so writing it never creates a dependency
  assign raw = h0_regwrite_i && (h0_rdst_i != 5'd0) &&
               ((h0_rdst_i == h1_ra1_i) || (h0_rdst_i == h1_ra2_i));

  assign pair_ok_o = !raw && !(h0_is_mem_i && h1_is_mem_i) && !h0_is_branch_i;

endmodule

// File: rtl/issue_queue.sv
// Issue queue: circular FIFO of decoded instructions with in-order issue into a
// one-cycle issue register. Dual issue is compiled in only with ISSUE_DUAL_EN.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int QDEPTH = 8
) (
  input logic          clk,
  input logic          resetn,
  issue_queue_if.slave bus
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  issue_entry_t  mem_q [QDEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, head1_ptr, tail1_ptr;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    iss_valid_q, iss_valid_d;
  issued_t [1:0] iss_data_q, iss_data_d;
  issue_entry_t  head0, head1;
  logic          enq_rdy, enq0, enq1, issue0, issue1;
  logic [1:0]    n_enq, n_iss;

  assign head1_ptr = head_q + PW'(1);
  assign tail1_ptr = tail_q + PW'(1);
  assign head0     = mem_q[head_q];
  assign head1     = mem_q[head1_ptr];

  // Two free slots are always required so a full bundle can never be split
  assign enq_rdy = (CW'(QDEPTH) - cnt_q) >= CW'(2);
  assign enq0    = enq_rdy && bus.enq_valid[0];
  assign enq1    = enq0 && bus.enq_valid[1];

  assign issue0 = bus.ex_ready && (cnt_q != '0) &&
                  bus.byp_ra1[0].valid && bus.byp_ra2[0].valid;

`ifdef ISSUE_DUAL_EN
  logic pair_ok;

  issue_pair_check u_pair (
    .h0_regwrite_i  (head0.regwrite),
    .h0_rdst_i      (head0.rdst),
    .h0_is_mem_i    (head0.is_mem),
    .h0_is_branch_i (head0.is_branch),
    .h1_ra1_i       (head1.ra1),
    .h1_ra2_i       (head1.ra2),
    .h1_is_mem_i    (head1.is_mem),
    .pair_ok_o      (pair_ok)
  );

  assign issue1 = issue0 && (cnt_q >= CW'(2)) &&
                  bus.byp_ra1[1].valid && bus.byp_ra2[1].valid && pair_ok;
`else
  logic unused_dual;
  assign unused_dual = &{1'b0, bus.byp_ra1[1].valid, bus.byp_ra2[1].valid};
  assign issue1      = 1'b0;
`endif

  assign n_enq  = {1'b0, enq0} + {1'b0, enq1};
  assign n_iss  = {1'b0, issue0} + {1'b0, issue1};
  assign cnt_d  = cnt_q + CW'(n_enq) - CW'(n_iss);
  assign head_d = head_q + PW'(n_iss);
  assign tail_d = tail_q + PW'(n_enq);

  always_comb begin
    iss_valid_d = iss_valid_q;
    iss_data_d  = iss_data_q;
    if (bus.ex_ready) begin
      iss_valid_d = {issue1, issue0};
      iss_data_d  = '0;
      if (issue0) begin
        iss_data_d[0].entry = head0;
        iss_data_d[0].op1   = bus.byp_ra1[0].data;
        iss_data_d[0].op2   = bus.byp_ra2[0].data;
        iss_data_d[0].byp1  = bus.byp_ra1[0].bypass;
        iss_data_d[0].byp2  = bus.byp_ra2[0].bypass;
      end
      if (issue1) begin
        iss_data_d[1].entry = head1;
        iss_data_d[1].op1   = bus.byp_ra1[1].data;
        iss_data_d[1].op2   = bus.byp_ra2[1].data;
        iss_data_d[1].byp1  = bus.byp_ra1[1].bypass;
        iss_data_d[1].byp2  = bus.byp_ra2[1].bypass;
      end
    end
  end

  always_comb begin
    bus.byp_query = '0;
    if (cnt_q != '0) begin
      bus.byp_query[0].ra1 = head0.ra1;
      bus.byp_query[0].ra2 = head0.ra2;
    end
    if (cnt_q >= CW'(2)) begin
      bus.byp_query[1].ra1 = head1.ra1;
      bus.byp_query[1].ra2 = head1.ra2;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q      <= '0;
      tail_q      <= '0;
      cnt_q       <= '0;
      iss_valid_q <= '0;
      iss_data_q  <= '0;
    end else if (bus.flush) begin
      head_q      <= '0;
      tail_q      <= '0;
      cnt_q       <= '0;
      iss_valid_q <= '0;
      iss_data_q  <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      cnt_q       <= cnt_d;
      iss_valid_q <= iss_valid_d;
      iss_data_q  <= iss_data_d;
    end
  end

  // Entry storage carries no reset; stale entries are unreachable once pointers clear
  always_ff @(posedge clk) begin
    if (enq0) mem_q[tail_q] <= bus.enq_data[0];
    if (enq1) mem_q[tail1_ptr] <= bus.enq_data[1];
  end

  assign bus.enq_ready = enq_rdy;
  assign bus.iss_valid = iss_valid_q;
  assign bus.iss_data  = iss_data_q;
  assign bus.count     = cnt_q;

endmodule
